// File: rtl/dc_tag_pkg.sv
// Shared types for the data-cache tag lookup: request opcodes, FSM states and
// the stored line entry (fields sized for the widest supported configuration).
package dc_tag_pkg;
  localparam int TAG_MAX   = 32;
  localparam int RRPV_MAX  = 4;
  localparam int STATE_MAX = 8;

  typedef enum logic [1:0] {
    OP_LOOKUP   = 2'd0,
    OP_FILL     = 2'd1,
    OP_INVAL    = 2'd2,
    OP_SETSTATE = 2'd3
  } req_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AGE  = 2'd1,
    RESP = 2'd2
  } fsm_e;

  // Narrower configurations keep their upper field bits at zero.
  typedef struct packed {
    logic [TAG_MAX-1:0]   tag;
    logic [RRPV_MAX-1:0]  rrpv;
    logic [STATE_MAX-1:0] state;
  } line_t;
endpackage

// File: rtl/dc_rrip_victim.sv
// RRIP victim pick for one set: lowest invalid way first, else lowest way whose
// re-reference counter is saturated; found=0 means the set must be aged.
module dc_rrip_victim #(
  parameter int NUM_WAYS  = 8,
  parameter int RRPV_BITS = 2,
  parameter int WAY_W     = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0]                valid,
  input  logic [NUM_WAYS-1:0][RRPV_BITS-1:0] rrpv,
  output logic [WAY_W-1:0]                   way,
  output logic                               found
);
  always_comb begin
    way   = '0;
    found = 1'b0;
    // Descending scans so the lowest qualifying way is the last write.
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid[w] && (rrpv[w] == '1)) begin
        way   = WAY_W'(w);
        found = 1'b1;
      end
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        way   = WAY_W'(w);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dc_tag_lookup.sv
// Set-associative tag array with coherence state and RRIP replacement.
// One request in flight; a full-set miss ages the set until a victim appears.
module dc_tag_lookup
  import dc_tag_pkg::*;
#(
  parameter int NUM_WAYS   = 8,
  parameter int NUM_SETS   = 32,
  parameter int TAG_BITS   = 18,
  parameter int RRPV_BITS  = 2,
  parameter int STATE_BITS = 3,
  parameter int SET_W      = $clog2(NUM_SETS),
  parameter int WAY_W      = $clog2(NUM_WAYS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_retry,
  input  logic [1:0]            req_op,
  input  logic [SET_W-1:0]      req_set,
  input  logic [TAG_BITS-1:0]   req_tag,
  input  logic [WAY_W-1:0]      req_way,
  input  logic [STATE_BITS-1:0] req_state,
  output logic                  ack_valid,
  input  logic                  ack_retry,
  output logic                  ack_hit,
  output logic [WAY_W-1:0]      ack_way,
  output logic [STATE_BITS-1:0] ack_state,
  output logic [TAG_BITS-1:0]   ack_victim_tag,
  output logic [STATE_BITS-1:0] ack_victim_state
);
  localparam logic [RRPV_BITS-1:0] RMAX  = '1;
  localparam logic [RRPV_BITS-1:0] RFILL = RMAX - 1'b1;

  line_t mem [NUM_SETS][NUM_WAYS];

  fsm_e                fsm, fsm_nxt;
  req_op_e             op;
  logic [SET_W-1:0]    lat_set, sel_set;
  logic                accept;

  line_t                              ln [NUM_WAYS];
  logic [NUM_WAYS-1:0]                valid, match;
  logic [NUM_WAYS-1:0][RRPV_BITS-1:0] rrpv_cur, rrpv_age, rrpv_vic;
  logic                               hit, vic_found;
  logic [WAY_W-1:0]                   hit_way, vic_way;

  logic                  rsp_ld, n_hit;
  logic [WAY_W-1:0]      n_way;
  logic [STATE_BITS-1:0] n_state, n_vstate;
  logic [TAG_BITS-1:0]   n_vtag;

  assign op      = req_op_e'(req_op);
  assign accept  = (fsm == IDLE) && req_valid;
  // While aging, the set comes from the latched request, not the live bus.
  assign sel_set = (fsm == AGE) ? lat_set : req_set;

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    assign ln[w]       = mem[sel_set][w];
    assign valid[w]    = ln[w].state != '0;
    assign match[w]    = valid[w] && (ln[w].tag == TAG_MAX'(req_tag));
    assign rrpv_cur[w] = ln[w].rrpv[RRPV_BITS-1:0];
    assign rrpv_age[w] = (rrpv_cur[w] == RMAX) ? RMAX : rrpv_cur[w] + 1'b1;
  end

  assign rrpv_vic = (fsm == AGE) ? rrpv_age : rrpv_cur;

  always_comb begin
    hit     = |match;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (match[w]) hit_way = WAY_W'(w);
  end

  dc_rrip_victim #(
    .NUM_WAYS  (NUM_WAYS),
    .RRPV_BITS (RRPV_BITS),
    .WAY_W     (WAY_W)
  ) u_victim (
    .valid (valid),
    .rrpv  (rrpv_vic),
    .way   (vic_way),
    .found (vic_found)
  );

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (req_valid)
              fsm_nxt = (op == OP_LOOKUP && !hit && !vic_found) ? AGE : RESP;
      AGE:  if (vic_found) fsm_nxt = RESP;
      RESP: if (!ack_retry) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  assign req_retry = fsm != IDLE;
  assign ack_valid = fsm == RESP;

  always_comb begin
    rsp_ld   = 1'b0;
    n_hit    = hit;
    n_way    = hit ? hit_way : vic_way;
    n_state  = hit ? ln[hit_way].state[STATE_BITS-1:0] : '0;
    n_vtag   = hit ? '0 : ln[vic_way].tag[TAG_BITS-1:0];
    n_vstate = hit ? '0 : ln[vic_way].state[STATE_BITS-1:0];
    if (accept) begin
      rsp_ld = !(op == OP_LOOKUP && !hit && !vic_found);
      if (op == OP_FILL) begin
        n_hit    = 1'b0;
        n_way    = req_way;
        n_state  = '0;
        n_vtag   = ln[req_way].tag[TAG_BITS-1:0];
        n_vstate = ln[req_way].state[STATE_BITS-1:0];
      end
    end else if (fsm == AGE) begin
      rsp_ld   = vic_found;
      n_hit    = 1'b0;
      n_way    = vic_way;
      n_state  = '0;
      n_vtag   = ln[vic_way].tag[TAG_BITS-1:0];
      n_vstate = ln[vic_way].state[STATE_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm              <= IDLE;
      lat_set          <= '0;
      ack_hit          <= 1'b0;
      ack_way          <= '0;
      ack_state        <= '0;
      ack_victim_tag   <= '0;
      ack_victim_state <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          mem[s][w] <= '{tag: '0, rrpv: RRPV_MAX'(RMAX), state: '0};
    end else begin
      fsm <= fsm_nxt;
      if (rsp_ld) begin
        ack_hit          <= n_hit;
        ack_way          <= n_way;
        ack_state        <= n_state;
        ack_victim_tag   <= n_vtag;
        ack_victim_state <= n_vstate;
      end
      if (accept) begin
        lat_set <= req_set;
        case (op)
          OP_LOOKUP:   if (hit) mem[req_set][hit_way].rrpv <= '0;
          OP_FILL:     mem[req_set][req_way] <= '{tag:   TAG_MAX'(req_tag),
                                                  rrpv:  RRPV_MAX'(RFILL),
                                                  state: STATE_MAX'(req_state)};
          OP_INVAL:    if (hit) mem[req_set][hit_way].state <= '0;
          OP_SETSTATE: if (hit) mem[req_set][hit_way].state <= STATE_MAX'(req_state);
          default: ;
        endcase
      end
      // Each aging cycle commits the incremented counters, including the exit cycle.
      if (fsm == AGE)
        for (int w = 0; w < NUM_WAYS; w++)
          mem[lat_set][w].rrpv <= RRPV_MAX'(rrpv_age[w]);
    end
  end
endmodule

// File: tb/tb_dc_tag_lookup.sv
// Directed bench for dc_tag_lookup: expected responses are queued at issue and
// compared when the consumer takes the response.
module tb_dc_tag_lookup;
  localparam logic [1:0] LK = 2'd0, FL = 2'd1, IV = 2'd2, SS = 2'd3;

  typedef struct packed {
    logic        hit;
    logic [2:0]  way;
    logic [2:0]  state;
    logic [17:0] vtag;
    logic [2:0]  vstate;
  } exp_t;

  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_retry;
  logic [1:0]  req_op = '0;
  logic [4:0]  req_set = '0;
  logic [17:0] req_tag = '0;
  logic [2:0]  req_way = '0, req_state = '0;
  logic        ack_valid, ack_retry = 1'b0, ack_hit;
  logic [2:0]  ack_way, ack_state, ack_victim_state;
  logic [17:0] ack_victim_tag;

  int   n_tests = 0, n_fail = 0;
  exp_t sb [$];
  exp_t e_mon;

  always #5 clk = ~clk;

  dc_tag_lookup dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_retry(req_retry), .req_op(req_op),
    .req_set(req_set), .req_tag(req_tag), .req_way(req_way), .req_state(req_state),
    .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_hit(ack_hit),
    .ack_way(ack_way), .ack_state(ack_state),
    .ack_victim_tag(ack_victim_tag), .ack_victim_state(ack_victim_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ack_valid && !ack_retry) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        e_mon = sb.pop_front();
        chk("ack_hit",    32'(ack_hit),          32'(e_mon.hit));
        chk("ack_way",    32'(ack_way),          32'(e_mon.way));
        chk("ack_state",  32'(ack_state),        32'(e_mon.state));
        chk("ack_vtag",   32'(ack_victim_tag),   32'(e_mon.vtag));
        chk("ack_vstate", 32'(ack_victim_state), 32'(e_mon.vstate));
      end
    end
  end

  // Returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input int set, input logic [17:0] tag,
                      input int way, input logic [2:0] st);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_set = 5'(set);
    req_tag = tag; req_way = 3'(way); req_state = st;
    while (req_retry && n < 50) begin @(negedge clk); n++; end
    if (req_retry) chk("accept_timeout", 1, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycles from acceptance to ack_valid, and cycles req_retry stays high.
  task automatic await_done(output int lat, output int rc);
    lat = -1; rc = 0;
    for (int i = 0; i < 20; i++) begin
      if (ack_valid && lat < 0) lat = i;
      if (!req_retry) break;
      rc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic op_chk(input string name, input logic [1:0] op, input int set,
                        input logic [17:0] tag, input int way, input logic [2:0] st,
                        input exp_t e, input int exp_lat, input int exp_rc);
    int lat, rc;
    sb.push_back(e);
    send(op, set, tag, way, st);
    await_done(lat, rc);
    chk({name, "_lat"},   32'(lat), 32'(exp_lat));
    chk({name, "_retry"}, 32'(rc),  32'(exp_rc));
  endtask

  initial begin
    int bad_st, bad_rr, lat, rc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack_valid", 32'(ack_valid), 0);
    chk("rst_req_retry", 32'(req_retry), 0);
    chk("rst_ack_data",  {ack_hit, ack_way, ack_state, ack_victim_tag, ack_victim_state}, 0);
    chk("rst_rrpv",      32'(dut.mem[3][4].rrpv), 3);
    @(negedge clk); reset = 1'b0;

    // Cold miss: lowest invalid way is the victim.
    op_chk("lk_cold", LK, 3, 18'h155, 0, 0, '{0, 0, 0, 0, 0}, 0, 1);
    op_chk("fill35",  FL, 3, 18'h2AA, 5, 2, '{0, 5, 0, 0, 0}, 0, 1);
    chk("fill_rrpv", 32'(dut.mem[3][5].rrpv), 2);
    op_chk("lk_hit",  LK, 3, 18'h2AA, 0, 0, '{1, 5, 2, 0, 0}, 0, 1);
    chk("hit_rrpv",  32'(dut.mem[3][5].rrpv), 0);

    for (int w = 0; w < 8; w++)
      op_chk("fill7", FL, 7, 18'(18'h100 + w), w, 1, '{0, 3'(w), 0, 0, 0}, 0, 1);
    // Full set, all rrpv=2: one aging cycle, victim way 0.
    op_chk("lk_age", LK, 7, 18'h3FF, 0, 0, '{0, 0, 0, 18'h100, 1}, 1, 2);
    bad_rr = 0;
    for (int w = 0; w < 8; w++) if (dut.mem[7][w].rrpv != 3) bad_rr++;
    chk("age_rrpv", 32'(bad_rr), 0);

    // Consumer stall: response held, no new request taken.
    sb.push_back('{1, 5, 2, 0, 0});
    ack_retry = 1'b1;
    send(LK, 3, 18'h2AA, 0, 0);
    req_valid = 1'b1; req_op = FL; req_set = 5'd3; req_tag = 18'h0AB; req_way = 3'd1; req_state = 3'd4;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(ack_valid), 1);
      chk("hold_retry", 32'(req_retry), 1);
      chk("hold_data",  {ack_hit, ack_way, ack_state, ack_victim_tag, ack_victim_state},
                        {1'b1, 3'd5, 3'd2, 18'h0, 3'd0});
      @(posedge clk); #1;
    end
    req_valid = 1'b0; ack_retry = 1'b0;
    await_done(lat, rc);
    chk("hold_release", 32'(rc), 1);
    chk("hold_no_fill", 32'(dut.mem[3][1].state), 0);

    op_chk("inval",    IV, 7, 18'h102, 0, 0, '{1, 2, 1, 0, 0}, 0, 1);
    op_chk("lk_inv",   LK, 7, 18'h102, 0, 0, '{0, 2, 0, 18'h102, 0}, 0, 1);
    op_chk("inv_miss", IV, 7, 18'h0EE, 0, 0, '{0, 2, 0, 18'h102, 0}, 0, 1);
    op_chk("ss_hit",   SS, 3, 18'h2AA, 0, 5, '{1, 5, 2, 0, 0}, 0, 1);
    op_chk("lk_ss",    LK, 3, 18'h2AA, 0, 0, '{1, 5, 5, 0, 0}, 0, 1);
    op_chk("ss_miss",  SS, 3, 18'h777, 0, 4, '{0, 0, 0, 0, 0}, 0, 1);
    op_chk("lk_ssm",   LK, 3, 18'h777, 0, 0, '{0, 0, 0, 0, 0}, 0, 1);

    // Reset during aging: operation dropped, array cleared.
    for (int w = 0; w < 8; w++)
      op_chk("fill9", FL, 9, 18'(18'h200 + w), w, 3, '{0, 3'(w), 0, 0, 0}, 0, 1);
    send(LK, 9, 18'h3FF, 0, 0);
    chk("age_retry", 32'(req_retry), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_age_valid", 32'(ack_valid), 0);
    chk("rst_age_retry", 32'(req_retry), 0);
    bad_st = 0; bad_rr = 0;
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 8; w++) begin
        if (dut.mem[s][w].state != 0) bad_st++;
        if (dut.mem[s][w].rrpv != 3) bad_rr++;
      end
    chk("rst_age_states", 32'(bad_st), 0);
    chk("rst_age_rrpv",   32'(bad_rr), 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_age_quiet", 32'(ack_valid), 0);
    chk("sb_empty",      32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
